// File: rtl/data_addr_gen.sv
// ----------------------------------------------------------------------------
// data_addr_gen
//
// Window-sweep address generator feeding data_ram. For one input feature map
// it walks a conv layer in this order:
//   output row (oy) -> column tile (ROWS lanes) -> kernel row (ky) -> kernel col (kx)
// and emits one address beat per cycle. Each beat carries:
//   - the kernel offsets kx/ky
//   - the tile column base and the output row base
//   - the latched image base
// Window first/last markers travel with the address beat. The RAM data for
// that beat arrives one cycle later, so downstream logic must delay the
// markers if it needs them aligned with the data.
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   start           layer start pulse, accepted only when idle
//   hold            stall while running: counters freeze, no valid beat
//   STRIDE          conv stride (1..3), latched on start
//   KERNEL_DIM      kernel size K (1..IN_DIM), latched on start
//   IN_DIM          input map width = height (1..RAM_NUM), latched on start
//   image_index_in  ROM row base of this map, latched on start
//   image_index     latched image base
//   addr_r_x        kernel column offset kx (upper nibble always 0)
//   addr_r_y        kernel row offset ky
//   ram_select_r_x  tile column base = tile*ROWS*STRIDE
//   ram_select_r_y  output row base  = oy*STRIDE
//   data_out_valid  beat valid
//   win_first       valid beat with kx = ky = 0
//   win_last        valid beat with kx = ky = K-1
//   busy            controller not idle
//   done            one-cycle pulse at end of layer
//   cfg_err         illegal configuration seen on the last accepted start
// ----------------------------------------------------------------------------
module data_addr_gen #(
  parameter int ROWS    = 8,
  parameter int RAM_NUM = 32,
  parameter int ADDR_DW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
  input  logic [1:0]         STRIDE,
  input  logic [3:0]         KERNEL_DIM,
  input  logic [5:0]         IN_DIM,
  input  logic [8:0]         image_index_in,
  output logic [8:0]         image_index,
  output logic [7:0]         addr_r_x,
  output logic [3:0]         addr_r_y,
  output logic [ADDR_DW-1:0] ram_select_r_x,
  output logic [ADDR_DW-1:0] ram_select_r_y,
  output logic               data_out_valid,
  output logic               win_first,
  output logic               win_last,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int ROWS_LOG2 = $clog2(ROWS);
  // Wide enough to hold any dimension count up to and including RAM_NUM.
  localparam int DIM_W     = $clog2(RAM_NUM + 1);
  localparam int TS_W      = DIM_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Latched configuration
  logic [1:0]       stride_reg;
  logic [3:0]       k_reg;

  // Output-size calculation
  logic [DIM_W-1:0] rem_reg;
  logic [DIM_W-1:0] out_dim_reg;

  // Sweep counters
  logic [3:0]       kx_reg;
  logic [3:0]       ky_reg;
  logic [DIM_W-1:0] tile_reg;
  logic [DIM_W-1:0] oy_reg;

  // Combinational helpers
  logic [DIM_W-1:0] in_ext;
  logic [DIM_W-1:0] k_ext;
  logic [DIM_W-1:0] stride_ext;
  logic             cfg_bad;
  logic             start_ok;
  logic             prep_step;
  logic [TS_W-1:0]  tiles_sum;
  logic [DIM_W-1:0] tiles;
  logic             kx_last;
  logic             ky_last;
  logic             tile_last;
  logic             oy_last;
  logic             beat;
  logic             last_beat;
  logic [ADDR_DW-1:0] rx_base;
  logic [ADDR_DW-1:0] ry_base;

  assign in_ext     = DIM_W'(IN_DIM);
  assign k_ext      = DIM_W'(KERNEL_DIM);
  assign stride_ext = DIM_W'(stride_reg);

  // Configuration check uses the live inputs because it is evaluated in the
  // same cycle the configuration is latched.
  assign cfg_bad   = (STRIDE == 2'd0) || (KERNEL_DIM == 4'd0) || (k_ext > in_ext);
  assign start_ok  = (state_reg == S_IDLE) && start;

  // One output row is added per PREP cycle while the remaining span still
  // fits another stride; this is a divide by repeated subtraction.
  assign prep_step = (rem_reg >= stride_ext);

  // Ceiling division of out_dim by ROWS; one extra bit avoids wrap on the add.
  assign tiles_sum = {1'b0, out_dim_reg} + TS_W'(ROWS - 1);
  assign tiles     = DIM_W'(tiles_sum >> ROWS_LOG2);

  assign kx_last   = (kx_reg == (k_reg - 4'd1));
  assign ky_last   = (ky_reg == (k_reg - 4'd1));
  assign tile_last = (tile_reg == (tiles - DIM_W'(1)));
  assign oy_last   = (oy_reg == (out_dim_reg - DIM_W'(1)));

  // Bases are sized to ADDR_DW; legal configurations never exceed it.
  assign rx_base = ADDR_DW'(32'(tile_reg) * ROWS * 32'(stride_reg));
  assign ry_base = ADDR_DW'(32'(oy_reg) * 32'(stride_reg));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = cfg_bad ? S_DONE : S_PREP;
        end
      end
      S_PREP: begin
        if (!prep_step) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (last_beat) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM-decoded outputs and datapath controls
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = (state_reg != S_IDLE);
    // hold only matters while running; elsewhere there is no beat anyway.
    beat      = (state_reg == S_RUN) && !hold;
    last_beat = beat && kx_last && ky_last && tile_last && oy_last;
  end

  // --------------------------------------------------------------------------
  // Configuration, output-size calculation, sweep counters, beat outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_reg     <= '0;
      k_reg          <= '0;
      rem_reg        <= '0;
      out_dim_reg    <= '0;
      kx_reg         <= '0;
      ky_reg         <= '0;
      tile_reg       <= '0;
      oy_reg         <= '0;
      image_index    <= '0;
      addr_r_x       <= '0;
      addr_r_y       <= '0;
      ram_select_r_x <= '0;
      ram_select_r_y <= '0;
      data_out_valid <= 1'b0;
      win_first      <= 1'b0;
      win_last       <= 1'b0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      // Registered from state so the pulse lands the cycle after DONE.
      done           <= (state_reg == S_DONE);
      data_out_valid <= beat;
      win_first      <= beat && (kx_reg == 4'd0) && (ky_reg == 4'd0);
      win_last       <= beat && kx_last && ky_last;

      if (start_ok) begin
        stride_reg  <= STRIDE;
        k_reg       <= KERNEL_DIM;
        image_index <= image_index_in;
        cfg_err     <= cfg_bad;
        rem_reg     <= in_ext - k_ext;
        out_dim_reg <= DIM_W'(1);
        kx_reg      <= '0;
        ky_reg      <= '0;
        tile_reg    <= '0;
        oy_reg      <= '0;
      end

      if ((state_reg == S_PREP) && prep_step) begin
        rem_reg     <= rem_reg - stride_ext;
        out_dim_reg <= out_dim_reg + DIM_W'(1);
      end

      // Address registers only load on a valid beat, so during hold and
      // after the layer they keep the last issued beat.
      if (beat) begin
        addr_r_x       <= {4'b0000, kx_reg};
        addr_r_y       <= ky_reg;
        ram_select_r_x <= rx_base;
        ram_select_r_y <= ry_base;

        if (kx_last) begin
          kx_reg <= '0;
          if (ky_last) begin
            ky_reg <= '0;
            if (tile_last) begin
              tile_reg <= '0;
              if (oy_last) begin
                oy_reg <= '0;
              end else begin
                oy_reg <= oy_reg + DIM_W'(1);
              end
            end else begin
              tile_reg <= tile_reg + DIM_W'(1);
            end
          end else begin
            ky_reg <= ky_reg + 4'd1;
          end
        end else begin
          kx_reg <= kx_reg + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_addr_gen.sv
module tb_data_addr_gen;

  localparam int ROWS    = 8;
  localparam int RAM_NUM = 32;
  localparam int ADDR_DW = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               hold = 1'b0;
  logic [1:0]         STRIDE = '0;
  logic [3:0]         KERNEL_DIM = '0;
  logic [5:0]         IN_DIM = '0;
  logic [8:0]         image_index_in = '0;
  logic [8:0]         image_index;
  logic [7:0]         addr_r_x;
  logic [3:0]         addr_r_y;
  logic [ADDR_DW-1:0] ram_select_r_x;
  logic [ADDR_DW-1:0] ram_select_r_y;
  logic               data_out_valid;
  logic               win_first;
  logic               win_last;
  logic               busy;
  logic               done;
  logic               cfg_err;

  data_addr_gen #(.ROWS(ROWS), .RAM_NUM(RAM_NUM), .ADDR_DW(ADDR_DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .STRIDE(STRIDE), .KERNEL_DIM(KERNEL_DIM), .IN_DIM(IN_DIM),
    .image_index_in(image_index_in), .image_index(image_index),
    .addr_r_x(addr_r_x), .addr_r_y(addr_r_y),
    .ram_select_r_x(ram_select_r_x), .ram_select_r_y(ram_select_r_y),
    .data_out_valid(data_out_valid), .win_first(win_first), .win_last(win_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ax;
    logic [3:0] ay;
    logic [4:0] rx;
    logic [4:0] ry;
    logic       wf;
    logic       wl;
  } beat_t;

  logic [36:0] all_out;
  assign all_out = {image_index, addr_r_x, addr_r_y, ram_select_r_x, ram_select_r_y,
                    data_out_valid, win_first, win_last, busy, done, cfg_err};

  int total = 0;
  int bad = 0;

  beat_t obs_q[$];
  beat_t exp_q[$];
  int    edge_cnt = 0;
  int    done_cnt = 0;
  int    done_edge = 0;
  int    first_valid_edge = -1;
  int    last_valid_edge = -1;
  int    hold_viol = 0;
  int    stray_mark = 0;
  int    start_cyc = 0;
  logic  busy_at_done = 1'b0;
  logic  busy_at_last = 1'b0;
  logic  hold_smp = 1'b0;

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    hold_smp = hold;
    #1;
    edge_cnt++;
    if (data_out_valid) begin
      obs_q.push_back(beat_t'({addr_r_x, addr_r_y, ram_select_r_x, ram_select_r_y,
                               win_first, win_last}));
      if (first_valid_edge < 0) first_valid_edge = edge_cnt;
      last_valid_edge = edge_cnt;
      busy_at_last = busy;
    end
    if (hold_smp && data_out_valid) hold_viol++;
    if (!data_out_valid && (win_first || win_last)) stray_mark++;
    if (done) begin
      done_cnt++;
      done_edge = edge_cnt;
      busy_at_done = busy;
    end
  end

  task automatic clear_stats();
    obs_q.delete();
    done_cnt = 0;
    done_edge = 0;
    first_valid_edge = -1;
    last_valid_edge = -1;
    hold_viol = 0;
    stray_mark = 0;
  endtask

  // Reference sweep: plain nested loops in output order.
  task automatic build_expected(input int s, input int k, input int in);
    int od;
    int tl;
    beat_t b;
    exp_q.delete();
    od = (in - k) / s + 1;
    tl = (od + ROWS - 1) / ROWS;
    for (int oy = 0; oy < od; oy++)
      for (int t = 0; t < tl; t++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            b.ax = 8'(kx);
            b.ay = 4'(ky);
            b.rx = 5'(t * ROWS * s);
            b.ry = 5'(oy * s);
            b.wf = (kx == 0 && ky == 0) ? 1'b1 : 1'b0;
            b.wl = (kx == k - 1 && ky == k - 1) ? 1'b1 : 1'b0;
            exp_q.push_back(b);
          end
  endtask

  function automatic int seq_mismatches();
    int m = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  function automatic beat_t last_obs();
    beat_t b = '0;
    if (obs_q.size() > 0) b = obs_q[obs_q.size() - 1];
    return b;
  endfunction

  // Pulses start with the given config and waits for done. Optional random
  // hold, a mid-run start pulse with a different config, or a mid-run reset.
  task automatic run_layer(input int s, input int k, input int in, input int img,
                           input int hold_pct, input int inject_at, input int abort_at,
                           input int budget, output bit timed_out);
    bit injected = 1'b0;
    timed_out = 1'b1;
    @(negedge clk);
    clear_stats();
    hold = 1'b0;
    STRIDE = 2'(s);
    KERNEL_DIM = 4'(k);
    IN_DIM = 6'(in);
    image_index_in = 9'(img);
    start = 1'b1;
    start_cyc = edge_cnt;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
      if (abort_at > 0 && obs_q.size() >= abort_at) begin
        rst_n = 1'b0;
        hold = 1'b0;
        timed_out = 1'b0;
        break;
      end
      hold = (hold_pct > 0 && $urandom_range(0, 99) < hold_pct) ? 1'b1 : 1'b0;
      if (inject_at > 0 && !injected && obs_q.size() >= inject_at) begin
        start = 1'b1;
        STRIDE = 2'd1;
        KERNEL_DIM = 4'd2;
        IN_DIM = 6'd10;
        image_index_in = 9'd7;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    hold = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (all_out !== 37'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (all_out !== 37'd0) begin
      bad++;
      $display("FAIL idle_outputs: got %h expected 0", all_out);
    end
    $display("test_reset: reset and idle outputs checked");
  endtask

  task automatic test_s1_k5();
    bit to;
    beat_t lb;
    build_expected(1, 5, 32);
    run_layer(1, 5, 32, 100, 0, 0, 0, 6000, to);
    lb = last_obs();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL s1k5_timeout: done not seen"); end
    total++; if (obs_q.size() !== 2800) begin bad++; $display("FAIL s1k5_beats: got %0d expected 2800", obs_q.size()); end
    // 28 PREP cycles, then one RUN cycle to register the first beat.
    total++; if (first_valid_edge - start_cyc !== 30) begin bad++; $display("FAIL s1k5_latency: got %0d expected 30", first_valid_edge - start_cyc); end
    total++; if (seq_mismatches() !== 0) begin bad++; $display("FAIL s1k5_sequence: got %0d mismatches expected 0", seq_mismatches()); end
    total++; if (obs_q[0] !== beat_t'(24'h000002)) begin bad++; $display("FAIL s1k5_first_beat: got %h expected 000002", obs_q[0]); end
    total++; if (lb.ry !== 5'd27) begin bad++; $display("FAIL s1k5_last_ry: got %0d expected 27", lb.ry); end
    total++; if (lb.rx !== 5'd24) begin bad++; $display("FAIL s1k5_last_rx: got %0d expected 24", lb.rx); end
    total++; if (lb.ax !== 8'd4 || lb.ay !== 4'd4) begin bad++; $display("FAIL s1k5_last_kxy: got ax=%0d ay=%0d expected 4 4", lb.ax, lb.ay); end
    total++; if (lb.wl !== 1'b1) begin bad++; $display("FAIL s1k5_last_winlast: got %0d expected 1", lb.wl); end
    total++; if (done_edge - last_valid_edge !== 1) begin bad++; $display("FAIL s1k5_done_timing: got %0d expected 1", done_edge - last_valid_edge); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL s1k5_done_count: got %0d expected 1", done_cnt); end
    total++; if (busy_at_last !== 1'b1 || busy_at_done !== 1'b0) begin bad++; $display("FAIL s1k5_busy: got last=%0d done=%0d expected 1 0", busy_at_last, busy_at_done); end
    total++; if (image_index !== 9'd100 || cfg_err !== 1'b0) begin bad++; $display("FAIL s1k5_img_err: got img=%0d err=%0d expected 100 0", image_index, cfg_err); end
    total++; if (stray_mark !== 0) begin bad++; $display("FAIL s1k5_stray_marker: got %0d expected 0", stray_mark); end
    $display("test_s1_k5: beats=%0d done=%0d", obs_q.size(), done_cnt);
  endtask

  task automatic test_s2_k5();
    bit to;
    beat_t lb;
    build_expected(2, 5, 32);
    run_layer(2, 5, 32, 64, 0, 0, 0, 3000, to);
    lb = last_obs();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL s2k5_timeout: done not seen"); end
    total++; if (obs_q.size() !== 700) begin bad++; $display("FAIL s2k5_beats: got %0d expected 700", obs_q.size()); end
    total++; if (seq_mismatches() !== 0) begin bad++; $display("FAIL s2k5_sequence: got %0d mismatches expected 0", seq_mismatches()); end
    total++; if (lb.ry !== 5'd26 || lb.rx !== 5'd16) begin bad++; $display("FAIL s2k5_last_base: got ry=%0d rx=%0d expected 26 16", lb.ry, lb.rx); end
    total++; if (lb.wl !== 1'b1) begin bad++; $display("FAIL s2k5_last_winlast: got %0d expected 1", lb.wl); end
    $display("test_s2_k5: beats=%0d done=%0d", obs_q.size(), done_cnt);
  endtask

  task automatic test_hold();
    bit to;
    build_expected(1, 3, 32);
    run_layer(1, 3, 32, 3, 30, 0, 0, 8000, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL hold_timeout: done not seen"); end
    total++; if (obs_q.size() !== 1080) begin bad++; $display("FAIL hold_beats: got %0d expected 1080", obs_q.size()); end
    total++; if (seq_mismatches() !== 0) begin bad++; $display("FAIL hold_sequence: got %0d mismatches expected 0", seq_mismatches()); end
    total++; if (hold_viol !== 0) begin bad++; $display("FAIL hold_valid_during_hold: got %0d expected 0", hold_viol); end
    total++; if (done_cnt !== 1 || stray_mark !== 0) begin bad++; $display("FAIL hold_done_markers: got done=%0d stray=%0d expected 1 0", done_cnt, stray_mark); end
    $display("test_hold: beats=%0d done=%0d", obs_q.size(), done_cnt);
  endtask

  task automatic test_cfg_err();
    bit to;
    beat_t lb;
    // K = 0
    run_layer(1, 0, 32, 5, 0, 0, 0, 20, to);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_k0_err: got %0d expected 1", cfg_err); end
    total++; if (done_edge - start_cyc !== 2) begin bad++; $display("FAIL cfg_k0_done_delay: got %0d expected 2", done_edge - start_cyc); end
    total++; if (obs_q.size() !== 0 || done_cnt !== 1) begin bad++; $display("FAIL cfg_k0_beats: got beats=%0d done=%0d expected 0 1", obs_q.size(), done_cnt); end
    // K > IN
    run_layer(1, 6, 5, 6, 0, 0, 0, 20, to);
    total++; if (cfg_err !== 1'b1 || done_edge - start_cyc !== 2) begin bad++; $display("FAIL cfg_k6_in5: got err=%0d delay=%0d expected 1 2", cfg_err, done_edge - start_cyc); end
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL cfg_k6_beats: got %0d expected 0", obs_q.size()); end
    // STRIDE = 0
    run_layer(0, 3, 8, 7, 0, 0, 0, 20, to);
    total++; if (cfg_err !== 1'b1 || obs_q.size() !== 0) begin bad++; $display("FAIL cfg_s0: got err=%0d beats=%0d expected 1 0", cfg_err, obs_q.size()); end
    // Next legal start clears cfg_err: IN=4 K=2 S=1 -> out_dim 3, 1 tile, 12 beats
    build_expected(1, 2, 4);
    run_layer(1, 2, 4, 33, 0, 0, 0, 200, to);
    lb = last_obs();
    total++; if (to !== 1'b0 || cfg_err !== 1'b0) begin bad++; $display("FAIL small_err_clear: got to=%0d err=%0d expected 0 0", to, cfg_err); end
    total++; if (obs_q.size() !== 12 || seq_mismatches() !== 0) begin bad++; $display("FAIL small_seq: got beats=%0d mism=%0d expected 12 0", obs_q.size(), seq_mismatches()); end
    total++; if (lb.ry !== 5'd2 || lb.ax !== 8'd1 || lb.ay !== 4'd1 || image_index !== 9'd33) begin bad++; $display("FAIL small_last: got ry=%0d ax=%0d ay=%0d img=%0d expected 2 1 1 33", lb.ry, lb.ax, lb.ay, image_index); end
    // K = IN boundary, S=3 -> 1 output, 25 beats, single PREP cycle
    build_expected(3, 5, 5);
    run_layer(3, 5, 5, 1, 0, 0, 0, 200, to);
    total++; if (obs_q.size() !== 25 || seq_mismatches() !== 0) begin bad++; $display("FAIL kin_seq: got beats=%0d mism=%0d expected 25 0", obs_q.size(), seq_mismatches()); end
    total++; if (first_valid_edge - start_cyc !== 3) begin bad++; $display("FAIL kin_latency: got %0d expected 3", first_valid_edge - start_cyc); end
    $display("test_cfg_err: error cases and boundary layers done");
  endtask

  task automatic test_start_ignored();
    bit to;
    beat_t lb;
    // IN=32 K=3 S=2 -> out_dim 15, tiles 2, 270 beats
    build_expected(2, 3, 32);
    run_layer(2, 3, 32, 200, 0, 50, 0, 2000, to);
    lb = last_obs();
    total++; if (to !== 1'b0 || done_cnt !== 1) begin bad++; $display("FAIL ign_done: got to=%0d done=%0d expected 0 1", to, done_cnt); end
    total++; if (obs_q.size() !== 270 || seq_mismatches() !== 0) begin bad++; $display("FAIL ign_seq: got beats=%0d mism=%0d expected 270 0", obs_q.size(), seq_mismatches()); end
    total++; if (image_index !== 9'd200 || lb.ry !== 5'd28 || lb.rx !== 5'd16) begin bad++; $display("FAIL ign_latched: got img=%0d ry=%0d rx=%0d expected 200 28 16", image_index, lb.ry, lb.rx); end
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_restart: got busy=%0d expected 0", busy); end
    $display("test_start_ignored: beats=%0d", obs_q.size());
  endtask

  task automatic test_reset_mid();
    bit to;
    run_layer(1, 5, 32, 50, 0, 0, 100, 4000, to);
    #1;
    total++; if (all_out !== 37'd0) begin bad++; $display("FAIL rstmid_async: got %h expected 0", all_out); end
    total++; if (obs_q.size() !== 100) begin bad++; $display("FAIL rstmid_beats: got %0d expected 100", obs_q.size()); end
    repeat (3) @(negedge clk);
    total++; if (done_cnt !== 0 || all_out !== 37'd0) begin bad++; $display("FAIL rstmid_no_done: got done=%0d out=%h expected 0 0", done_cnt, all_out); end
    rst_n = 1'b1;
    @(negedge clk);
    build_expected(1, 3, 32);
    run_layer(1, 3, 32, 11, 0, 0, 0, 3000, to);
    total++; if (to !== 1'b0 || done_cnt !== 1) begin bad++; $display("FAIL rstmid_rerun_done: got to=%0d done=%0d expected 0 1", to, done_cnt); end
    total++; if (obs_q.size() !== 1080 || seq_mismatches() !== 0) begin bad++; $display("FAIL rstmid_rerun_seq: got beats=%0d mism=%0d expected 1080 0", obs_q.size(), seq_mismatches()); end
    $display("test_reset_mid: rerun beats=%0d", obs_q.size());
  endtask

  initial begin
    test_reset();
    test_s1_k5();
    test_s2_k5();
    test_hold();
    test_cfg_err();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
